sfp_frame_handler: RTL and testbench

- Aurora-side end of the SFP start/end-flag handshake that MPS_Core drives.
- TX path: on a tx-start pulse from the core, serialises the core's outgoing stream word into C_NUMBER_OF_FRAME AXIS beats toward the Aurora TX user interface.
- RX path: reassembles incoming Aurora RX beats into one stream word and returns a one-cycle rx-end pulse to the core.
- Sits between MPS_Core (o_stream_data/i_stream_data, tx_start/rx_end flags) and the Aurora 64B/66B core.

---
 rtl/sfp_frame_handler_if.sv | 33 +++
 rtl/sfp_frame_handler.sv | 192 +++++++++++++++++++
 tb/tb_sfp_frame_handler.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfp_frame_handler_if.sv
// Aurora-side AXIS bundle for sfp_frame_handler: TX master beats out, RX beats in.
// The master modport is the frame handler; the slave modport is the Aurora core side.
interface sfp_frame_handler_if #(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 64
);
   logic [C_AXIS_TDATA_WIDTH-1:0] o_m_axis_tdata;
   logic                          o_m_axis_tvalid;
   logic                          o_m_axis_tlast;
   logic                          i_m_axis_tready;
   logic [C_AXIS_TDATA_WIDTH-1:0] i_s_axis_tdata;
   logic                          i_s_axis_tvalid;
   logic                          i_s_axis_tlast;

   modport master (
      output o_m_axis_tdata,
      output o_m_axis_tvalid,
      output o_m_axis_tlast,
      input  i_m_axis_tready,
      input  i_s_axis_tdata,
      input  i_s_axis_tvalid,
      input  i_s_axis_tlast
   );

   modport slave (
      input  o_m_axis_tdata,
      input  o_m_axis_tvalid,
      input  o_m_axis_tlast,
      output i_m_axis_tready,
      output i_s_axis_tdata,
      output i_s_axis_tvalid,
      output i_s_axis_tlast
   );
endinterface

// File: rtl/sfp_frame_handler.sv
// SFP start/end-flag bridge between MPS_Core and Aurora: serialises TX words into AXIS beats and
// reassembles RX beats into words. Define SFP_LOOPBACK_EN to add the internal TX->RX loopback.
module sfp_frame_handler #(
   parameter int unsigned C_AXIS_TDATA_WIDTH = 64,
   parameter int unsigned C_NUMBER_OF_FRAME  = 2,
   parameter int unsigned C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
   parameter int unsigned C_RX_TIMEOUT       = 1000
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_channel_up,
`ifdef SFP_LOOPBACK_EN
   input  logic                        i_loopback,
`endif
   input  logic                        i_tx_start_flag,
   input  logic [C_DATA_FRAME_BIT-1:0] i_tx_data,
   sfp_frame_handler_if.master         axis,
   output logic [C_DATA_FRAME_BIT-1:0] o_rx_data,
   output logic                        o_rx_end_flag,
   output logic                        o_tx_busy,
   output logic                        o_tx_overrun,
   output logic                        o_rx_err
);

   localparam int unsigned W    = C_AXIS_TDATA_WIDTH;
   localparam int unsigned N    = C_NUMBER_OF_FRAME;
   localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned TmrW = $clog2(C_RX_TIMEOUT + 1);
   localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);
   localparam logic [TmrW-1:0] TmrMax  = TmrW'(C_RX_TIMEOUT - 1);

   typedef enum logic [1:0] {TxIdle, TxSend, TxDone} tx_state_e;
   typedef enum logic {RxIdle, RxCollect} rx_state_e;

   tx_state_e                 tx_state_q;
   logic                      start_q, start_prev_q;
   logic [C_DATA_FRAME_BIT-1:0] shadow_q;
   logic [CntW-1:0]           beat_q;
   logic [W-1:0]              tdata_q;
   logic                      tvalid_q, tlast_q, overrun_q;

   rx_state_e                 rx_state_q;
   logic [C_DATA_FRAME_BIT-1:0] asm_q, rx_data_q, rx_word;
   logic [CntW-1:0]           rx_cnt_q, rx_idx, beat_nxt;
   logic [TmrW-1:0]           timer_q;
   logic                      rx_end_q, rx_err_q, rx_timeout;

   logic                      tready_int, tx_accept, start_edge;
   logic                      rx_valid, rx_last;
   logic [W-1:0]              rx_beat;

`ifdef SFP_LOOPBACK_EN
   // Loopback hides TX from the link and feeds accepted beats straight into RX.
   assign tready_int           = i_loopback ? 1'b1 : axis.i_m_axis_tready;
   assign axis.o_m_axis_tvalid = tvalid_q & ~i_loopback;
   assign rx_valid             = i_loopback ? tx_accept : axis.i_s_axis_tvalid;
   assign rx_last              = i_loopback ? tlast_q   : axis.i_s_axis_tlast;
   assign rx_beat              = i_loopback ? tdata_q   : axis.i_s_axis_tdata;
`else
   assign tready_int           = axis.i_m_axis_tready;
   assign axis.o_m_axis_tvalid = tvalid_q;
   assign rx_valid             = axis.i_s_axis_tvalid;
   assign rx_last              = axis.i_s_axis_tlast;
   assign rx_beat              = axis.i_s_axis_tdata;
`endif

   assign axis.o_m_axis_tdata = tdata_q;
   assign axis.o_m_axis_tlast = tlast_q;
   assign tx_accept           = tvalid_q & tready_int;
   assign start_edge          = start_q & ~start_prev_q;
   assign beat_nxt            = beat_q + 1'b1;

   assign o_rx_data     = rx_data_q;
   assign o_rx_end_flag = rx_end_q;
   assign o_tx_busy     = (tx_state_q != TxIdle);
   assign o_tx_overrun  = overrun_q;
   assign o_rx_err      = rx_err_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tx_state_q   <= TxIdle;
         start_q      <= 1'b0;
         start_prev_q <= 1'b0;
         shadow_q     <= '0;
         beat_q       <= '0;
         tdata_q      <= '0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         start_q      <= i_tx_start_flag;
         start_prev_q <= start_q;
         overrun_q    <= 1'b0;
         unique case (tx_state_q)
            TxIdle: begin
               if (start_edge && i_channel_up) begin
                  shadow_q   <= i_tx_data;
                  beat_q     <= '0;
                  tdata_q    <= i_tx_data[W-1:0];
                  tvalid_q   <= 1'b1;
                  tlast_q    <= (N == 1);
                  tx_state_q <= TxSend;
               end else if (start_edge) begin
                  overrun_q  <= 1'b1;
               end
            end
            TxSend: begin
               if (start_edge) overrun_q <= 1'b1;
               if (!i_channel_up) begin
                  tvalid_q   <= 1'b0;
                  tlast_q    <= 1'b0;
                  tx_state_q <= TxIdle;
               end else if (tx_accept) begin
                  if (beat_q == LastIdx) begin
                     tvalid_q   <= 1'b0;
                     tlast_q    <= 1'b0;
                     tx_state_q <= TxDone;
                  end else begin
                     beat_q  <= beat_nxt;
                     tdata_q <= shadow_q[beat_nxt*W +: W];
                     tlast_q <= (beat_nxt == LastIdx);
                  end
               end
            end
            TxDone: begin
               if (start_edge) overrun_q <= 1'b1;
               tx_state_q <= TxIdle;
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   // A beat landing on the timeout cycle restarts assembly at slot 0.
   always_comb begin
      rx_timeout = (rx_state_q == RxCollect) && (timer_q == TmrMax);
      rx_idx     = rx_timeout ? '0 : rx_cnt_q;
      rx_word    = asm_q;
      rx_word[rx_idx*W +: W] = rx_beat;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_state_q <= RxIdle;
         asm_q      <= '0;
         rx_data_q  <= '0;
         rx_cnt_q   <= '0;
         timer_q    <= '0;
         rx_end_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_end_q <= 1'b0;
         rx_err_q <= 1'b0;
         if (!i_channel_up) begin
            if (rx_state_q == RxCollect) rx_err_q <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            timer_q    <= '0;
         end else begin
            if (rx_timeout) rx_err_q <= 1'b1;
            if (rx_valid) begin
               timer_q <= '0;
               if (rx_idx == LastIdx) begin
                  rx_state_q <= RxIdle;
                  rx_cnt_q   <= '0;
                  if (rx_last) begin
                     rx_data_q <= rx_word;
                     rx_end_q  <= 1'b1;
                  end else begin
                     rx_err_q  <= 1'b1;
                  end
               end else if (rx_last) begin
                  rx_state_q <= RxIdle;
                  rx_cnt_q   <= '0;
                  rx_err_q   <= 1'b1;
               end else begin
                  asm_q      <= rx_word;
                  rx_cnt_q   <= rx_idx + 1'b1;
                  rx_state_q <= RxCollect;
               end
            end else if (rx_timeout) begin
               rx_state_q <= RxIdle;
               rx_cnt_q   <= '0;
               timer_q    <= '0;
            end else if (rx_state_q == RxCollect) begin
               timer_q <= timer_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sfp_frame_handler.sv
// Self-checking bench for sfp_frame_handler: randomized TX/RX words against a word/beat model.
// The loopback scenario is compiled in only when SFP_LOOPBACK_EN is defined.
module tb_sfp_frame_handler;
   localparam int unsigned W  = 64;
   localparam int unsigned N  = 2;
   localparam int unsigned DW = W * N;
   localparam int unsigned TO = 1000;

   logic          clk = 1'b0;
   logic          rst;
   logic          channel_up;
   logic          tx_start;
   logic [DW-1:0] tx_data;
   logic [DW-1:0] rx_data;
   logic          rx_end, tx_busy, tx_overrun, rx_err;
`ifdef SFP_LOOPBACK_EN
   logic          loopback;
`endif

   sfp_frame_handler_if #(.C_AXIS_TDATA_WIDTH(W)) axis ();

   sfp_frame_handler #(
      .C_AXIS_TDATA_WIDTH(W),
      .C_NUMBER_OF_FRAME (N),
      .C_RX_TIMEOUT      (TO)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_channel_up   (channel_up),
`ifdef SFP_LOOPBACK_EN
      .i_loopback     (loopback),
`endif
      .i_tx_start_flag(tx_start),
      .i_tx_data      (tx_data),
      .axis           (axis),
      .o_rx_data      (rx_data),
      .o_rx_end_flag  (rx_end),
      .o_tx_busy      (tx_busy),
      .o_tx_overrun   (tx_overrun),
      .o_rx_err       (rx_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_overrun = 0, n_end = 0, n_err = 0;
   logic [W-1:0]  beat_q[$];
   logic          last_q[$];
   logic [DW-1:0] exp_rx;

   // Passive monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (axis.o_m_axis_tvalid && axis.i_m_axis_tready) begin
            beat_q.push_back(axis.o_m_axis_tdata);
            last_q.push_back(axis.o_m_axis_tlast);
         end
         if (tx_overrun) n_overrun++;
         if (rx_end) n_end++;
         if (rx_err) n_err++;
      end
   end

   function automatic logic [W-1:0] model_beat(input logic [DW-1:0] w, input int k);
      return W'(w >> (W * k));
   endfunction

   function automatic logic [DW-1:0] model_word(input logic [W-1:0] b0, input logic [W-1:0] b1);
      return (DW'(b1) << W) | DW'(b0);
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++) w = (w << 32) | DW'($urandom);
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_beat(input logic [W-1:0] d, input logic last);
      axis.i_s_axis_tdata  = d;
      axis.i_s_axis_tvalid = 1'b1;
      axis.i_s_axis_tlast  = last;
      tick();
      axis.i_s_axis_tvalid = 1'b0;
      axis.i_s_axis_tlast  = 1'b0;
   endtask

   // Waits (bounded) for TX to go idle, optionally with random backpressure.
   task automatic wait_tx_idle(input bit rand_ready);
      int i;
      for (i = 0; i < 60; i++) begin
         if (!tx_busy) break;
         if (rand_ready) axis.i_m_axis_tready = 1'($urandom_range(0, 1));
         tick();
      end
      axis.i_m_axis_tready = 1'b1;
      n_checks++;
      if (tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_idle_timeout: busy=%0b after %0d cycles, required 0", tx_busy, i);
      end
   endtask

   task automatic check_beats(input string name, input int base, input logic [DW-1:0] w);
      n_checks++;
      if (beat_q.size() !== base + N) begin
         n_fail++;
         $display("FAIL %s_count: got %0d beats, required %0d", name, beat_q.size() - base, N);
      end else begin
         for (int k = 0; k < N; k++) begin
            n_checks++;
            if (beat_q[base+k] !== model_beat(w, k) || last_q[base+k] !== (k == N - 1)) begin
               n_fail++;
               $display("FAIL %s_beat%0d: got %h last=%0b, required %h last=%0b", name, k,
                        beat_q[base+k], last_q[base+k], model_beat(w, k), (k == N - 1));
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({axis.o_m_axis_tvalid, axis.o_m_axis_tlast, rx_end, tx_busy, tx_overrun, rx_err}
          !== 6'b0 || axis.o_m_axis_tdata !== '0 || rx_data !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: tvalid=%0b tlast=%0b end=%0b busy=%0b ovr=%0b err=%0b tdata=%h rx=%h, required all 0",
                  axis.o_m_axis_tvalid, axis.o_m_axis_tlast, rx_end, tx_busy, tx_overrun, rx_err,
                  axis.o_m_axis_tdata, rx_data);
      end
      rst = 1'b0;
      exp_rx = '0;
      tick();
   endtask

   task automatic test_tx_basic();
      int base = beat_q.size();
      int ovr  = n_overrun;
      logic [DW-1:0] w = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      tx_data = w;
      tx_start = 1'b1;
      tick();
      n_checks++;
      if (axis.o_m_axis_tvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_latency_early: tvalid=%0b, required 0", axis.o_m_axis_tvalid);
      end
      tick();
      n_checks++;
      if (axis.o_m_axis_tvalid !== 1'b1 || axis.o_m_axis_tdata !== 64'h5555_6666_7777_8888 ||
          axis.o_m_axis_tlast !== 1'b0) begin
         n_fail++;
         $display("FAIL tx_first_beat: tvalid=%0b tdata=%h tlast=%0b, required 1 5555666677778888 0",
                  axis.o_m_axis_tvalid, axis.o_m_axis_tdata, axis.o_m_axis_tlast);
      end
      wait_tx_idle(1'b0);
      tx_start = 1'b0;
      tick();
      check_beats("tx_basic", base, w);
      for (int r = 0; r < 4; r++) begin
         base = beat_q.size();
         w = rand_word();
         tx_data = w;
         tx_start = 1'b1;
         tick();
         tick();
         wait_tx_idle(1'b1);
         tx_start = 1'b0;
         tick();
         check_beats("tx_random", base, w);
      end
      n_checks++;
      if (n_overrun !== ovr) begin
         n_fail++;
         $display("FAIL tx_basic_overrun: got %0d pulses, required 0", n_overrun - ovr);
      end
   endtask

   task automatic test_backpressure();
      int base = beat_q.size();
      int ovr  = n_overrun;
      logic [DW-1:0] w = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
      axis.i_m_axis_tready = 1'b1;
      tx_data  = w;
      tx_start = 1'b1;
      tick();
      tick();
      tick();
      axis.i_m_axis_tready = 1'b0;
      tx_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) tx_start = 1'b1;
         if (i == 2) tx_data = ~w;
         tick();
         n_checks++;
         if (axis.o_m_axis_tvalid !== 1'b1 || axis.o_m_axis_tdata !== model_beat(w, 1) ||
             axis.o_m_axis_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: tvalid=%0b tdata=%h tlast=%0b, required 1 %h 1", i,
                     axis.o_m_axis_tvalid, axis.o_m_axis_tdata, axis.o_m_axis_tlast,
                     model_beat(w, 1));
         end
      end
      axis.i_m_axis_tready = 1'b1;
      wait_tx_idle(1'b0);
      tx_start = 1'b0;
      tick();
      tick();
      check_beats("bp", base, w);
      n_checks++;
      if (n_overrun - ovr !== 1) begin
         n_fail++;
         $display("FAIL bp_overrun: got %0d pulses, required 1", n_overrun - ovr);
      end
   endtask

   task automatic test_rx_good();
      int ends = n_end;
      logic [W-1:0] b0, b1;
      rx_beat(64'hA, 1'b0);
      rx_beat(64'hB, 1'b1);
      exp_rx = model_word(64'hA, 64'hB);
      n_checks++;
      if (rx_end !== 1'b1 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_good: end=%0b data=%h, required 1 %h", rx_end, rx_data, exp_rx);
      end
      tick();
      n_checks++;
      if (rx_end !== 1'b0) begin
         n_fail++;
         $display("FAIL rx_end_width: end=%0b one cycle later, required 0", rx_end);
      end
      for (int r = 0; r < 4; r++) begin
         b0 = {$urandom, $urandom};
         b1 = {$urandom, $urandom};
         rx_beat(b0, 1'b0);
         repeat ($urandom_range(0, 6)) tick();
         rx_beat(b1, 1'b1);
         exp_rx = model_word(b0, b1);
         n_checks++;
         if (rx_end !== 1'b1 || rx_data !== exp_rx) begin
            n_fail++;
            $display("FAIL rx_random%0d: end=%0b data=%h, required 1 %h", r, rx_end, rx_data, exp_rx);
         end
         repeat ($urandom_range(1, 4)) tick();
      end
      n_checks++;
      if (n_end - ends !== 5) begin
         n_fail++;
         $display("FAIL rx_end_count: got %0d pulses, required 5", n_end - ends);
      end
   endtask

   task automatic test_rx_errors();
      int i;
      logic [W-1:0] x = {$urandom, $urandom};
      logic [W-1:0] y = {$urandom, $urandom};
      rx_beat(x, 1'b1);
      n_checks++;
      if (rx_err !== 1'b1 || rx_end !== 1'b0 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_early_last: err=%0b end=%0b data=%h, required 1 0 %h", rx_err, rx_end,
                  rx_data, exp_rx);
      end
      tick();
      rx_beat(x, 1'b0);
      rx_beat(y, 1'b0);
      n_checks++;
      if (rx_err !== 1'b1 || rx_end !== 1'b0 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_missing_last: err=%0b end=%0b data=%h, required 1 0 %h", rx_err, rx_end,
                  rx_data, exp_rx);
      end
      tick();
      rx_beat(x, 1'b0);
      for (i = 1; i <= TO + 100; i++) begin
         tick();
         if (rx_err) break;
      end
      n_checks++;
      if (i !== TO || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_timeout: err at idle clock %0d data=%h, required %0d %h", i, rx_data,
                  TO, exp_rx);
      end
      tick();
      rx_beat(y, 1'b0);
      repeat (TO - 1) tick();
      rx_beat(x, 1'b0);
      n_checks++;
      if (rx_err !== 1'b1) begin
         n_fail++;
         $display("FAIL rx_timeout_edge_err: err=%0b, required 1", rx_err);
      end
      rx_beat(y, 1'b1);
      exp_rx = model_word(x, y);
      n_checks++;
      if (rx_end !== 1'b1 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL rx_timeout_edge_word: end=%0b data=%h, required 1 %h", rx_end, rx_data,
                  exp_rx);
      end
      tick();
   endtask

   task automatic test_channel_drop();
      int base = beat_q.size();
      int errs = n_err;
      logic [DW-1:0] w = rand_word();
      logic [W-1:0] a = {$urandom, $urandom};
      logic [W-1:0] b = {$urandom, $urandom};
      axis.i_m_axis_tready = 1'b1;
      tx_data  = w;
      tx_start = 1'b1;
      tick();
      tick();
      rx_beat(a, 1'b0);
      axis.i_m_axis_tready = 1'b0;
      channel_up = 1'b0;
      tick();
      n_checks++;
      if (axis.o_m_axis_tvalid !== 1'b0 || rx_err !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL chdrop_now: tvalid=%0b err=%0b busy=%0b, required 0 1 0",
                  axis.o_m_axis_tvalid, rx_err, tx_busy);
      end
      tick();
      channel_up = 1'b1;
      tx_start = 1'b0;
      axis.i_m_axis_tready = 1'b1;
      tick();
      n_checks++;
      if (n_err - errs !== 1 || beat_q.size() - base !== 1 || beat_q[base] !== model_beat(w, 0)) begin
         n_fail++;
         $display("FAIL chdrop_totals: errs=%0d beats=%0d, required 1 1", n_err - errs,
                  beat_q.size() - base);
      end
      rx_beat(b, 1'b0);
      rx_beat(a, 1'b1);
      exp_rx = model_word(b, a);
      n_checks++;
      if (rx_end !== 1'b1 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL chdrop_recover: end=%0b data=%h, required 1 %h", rx_end, rx_data, exp_rx);
      end
      tick();
   endtask

   task automatic test_simultaneous();
      int base = beat_q.size();
      logic [DW-1:0] w = rand_word();
      logic [W-1:0] a = {$urandom, $urandom};
      logic [W-1:0] b = {$urandom, $urandom};
      tx_data  = w;
      tx_start = 1'b1;
      rx_beat(a, 1'b0);
      rx_beat(b, 1'b1);
      exp_rx = model_word(a, b);
      n_checks++;
      if (rx_end !== 1'b1 || rx_data !== exp_rx || axis.o_m_axis_tvalid !== 1'b1) begin
         n_fail++;
         $display("FAIL simult: end=%0b data=%h tvalid=%0b, required 1 %h 1", rx_end, rx_data,
                  axis.o_m_axis_tvalid, exp_rx);
      end
      wait_tx_idle(1'b0);
      tx_start = 1'b0;
      tick();
      check_beats("simult", base, w);
   endtask

   task automatic test_reset_mid();
      int pulses = n_err + n_end + n_overrun;
      tx_data  = rand_word();
      tx_start = 1'b1;
      tick();
      tick();
      rx_beat(64'h5, 1'b0);
      rst = 1'b1;
      tx_start = 1'b0;
      tick();
      rst = 1'b0;
      exp_rx = '0;
      n_checks++;
      if (tx_busy !== 1'b0 || axis.o_m_axis_tvalid !== 1'b0 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%0b tvalid=%0b data=%h, required 0 0 0", tx_busy,
                  axis.o_m_axis_tvalid, rx_data);
      end
      repeat (3) tick();
      n_checks++;
      if (n_err + n_end + n_overrun !== pulses) begin
         n_fail++;
         $display("FAIL reset_mid_pulses: got %0d pulses, required 0",
                  n_err + n_end + n_overrun - pulses);
      end
   endtask

`ifdef SFP_LOOPBACK_EN
   task automatic test_loopback();
      int ends = n_end;
      int seen_valid = 0;
      logic [DW-1:0] w = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
      loopback = 1'b1;
      axis.i_m_axis_tready = 1'b0;
      tx_data  = w;
      tx_start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (axis.o_m_axis_tvalid) seen_valid++;
      end
      exp_rx = w;
      n_checks++;
      if (seen_valid !== 0 || n_end - ends !== 1 || rx_data !== exp_rx) begin
         n_fail++;
         $display("FAIL loopback: tvalid_cycles=%0d ends=%0d data=%h, required 0 1 %h", seen_valid,
                  n_end - ends, rx_data, exp_rx);
      end
      tx_start = 1'b0;
      loopback = 1'b0;
      axis.i_m_axis_tready = 1'b1;
      tick();
   endtask
`endif

   initial begin
      rst        = 1'b1;
      channel_up = 1'b1;
      tx_start   = 1'b0;
      tx_data    = '0;
      exp_rx     = '0;
`ifdef SFP_LOOPBACK_EN
      loopback   = 1'b0;
`endif
      axis.i_m_axis_tready = 1'b1;
      axis.i_s_axis_tdata  = '0;
      axis.i_s_axis_tvalid = 1'b0;
      axis.i_s_axis_tlast  = 1'b0;
      test_reset();
      test_tx_basic();
      test_backpressure();
      test_rx_good();
      test_rx_errors();
      test_channel_drop();
      test_simultaneous();
      test_reset_mid();
`ifdef SFP_LOOPBACK_EN
      test_loopback();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
